aes_key_sched_ctrl: RTL and testbench

//  Sequencer for the AES-128 key-expansion datapath (key_expand). Accepts a cipher key,

---
 rtl/aes_key_sched_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequences the AES-128 key-expansion datapath one round at a time.
// It supplies the previous round key and the rcon word to key_expand, then captures
// every round key into an internal file that the cipher core reads at random.
// The first key byte sits in the most significant bits of each 128-bit word.
module aes_key_sched_ctrl #(
    parameter int NR     = 10,
    parameter int XE_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_start,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [127:0] xe_temp_key,
    output logic [127:0] xe_m_key,
    output logic [31:0]  xe_rcon,
    input  logic [127:0] xe_out_key,
    input  logic [3:0]   rk_rd_addr,
    output logic [127:0] rk_rd_data,
    output logic [1:0]   state_dbg
);

    localparam int WCW = (XE_LAT > 1) ? $clog2(XE_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [3:0]     round;
    logic [WCW-1:0] wait_cnt;
    logic [127:0]   rk [0:NR];
    logic           start_acc;

    // AES round constant for expansion rounds 1..10; anything else maps to 0.
    function automatic logic [7:0] rc_byte(input logic [3:0] r);
        case (r)
            4'd1:    rc_byte = 8'h01;
            4'd2:    rc_byte = 8'h02;
            4'd3:    rc_byte = 8'h04;
            4'd4:    rc_byte = 8'h08;
            4'd5:    rc_byte = 8'h10;
            4'd6:    rc_byte = 8'h20;
            4'd7:    rc_byte = 8'h40;
            4'd8:    rc_byte = 8'h80;
            4'd9:    rc_byte = 8'h1b;
            4'd10:   rc_byte = 8'h36;
            default: rc_byte = 8'h00;
        endcase
    endfunction

    // Load handshake: a key transfers on any rising edge where key_start and
    // key_ready are both high. key_ready is only high in IDLE and DONE, so a
    // key_start raised while an expansion runs is simply dropped.
    assign start_acc = key_start & key_ready;

    // The mask input of key_expand is unused for plain key expansion.
    assign xe_m_key  = '0;
    assign state_dbg = state;

    // Sequencer: accept a key, run ISSUE/WAIT once per round, then flag DONE.
    // xe_temp_key doubles as the current-key register: it always holds the
    // most recently produced round key, which is what the next round needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            round       <= 4'd0;
            wait_cnt    <= '0;
            key_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            keys_valid  <= 1'b0;
            xe_temp_key <= '0;
            xe_rcon     <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (start_acc) begin
                // A new load always wins, including one arriving in the DONE cycle.
                rk[0]       <= key_in;
                xe_temp_key <= key_in;
                xe_rcon     <= {rc_byte(4'd1), 24'h0};
                round       <= 4'd1;
                keys_valid  <= 1'b0;
                busy        <= 1'b1;
                key_ready   <= 1'b0;
                state       <= S_ISSUE;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_ISSUE: begin
                        wait_cnt <= WCW'(XE_LAT - 1);
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - WCW'(1);
                        end else begin
                            rk[round]   <= xe_out_key;
                            xe_temp_key <= xe_out_key;
                            if (round == 4'(NR)) begin
                                xe_rcon   <= '0;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                key_ready <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                round   <= round + 4'd1;
                                xe_rcon <= {rc_byte(round + 4'd1), 24'h0};
                                state   <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        keys_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Random-access read of the round-key file; indices past NR read as zero.
    always_comb begin
        rk_rd_data = '0;
        if (rk_rd_addr <= 4'(NR)) begin
            rk_rd_data = rk[rk_rd_addr];
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: drives the key-schedule sequencer against a behavioural
// key_expand model (latency 1 and latency 3 builds) and scores every round key.
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    // ---------------- DUT with XE_LAT = 1 ----------------
    logic [127:0] key_in;
    logic         key_start, key_ready, busy, done, keys_valid;
    logic [127:0] xe_temp_key, xe_m_key, xe_out_key, rk_rd_data;
    logic [31:0]  xe_rcon;
    logic [3:0]   rk_rd_addr;
    logic [1:0]   state_dbg;

    aes_key_sched_ctrl #(.NR(NR), .XE_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_start(key_start),
        .key_ready(key_ready), .busy(busy), .done(done), .keys_valid(keys_valid),
        .xe_temp_key(xe_temp_key), .xe_m_key(xe_m_key), .xe_rcon(xe_rcon),
        .xe_out_key(xe_out_key), .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data),
        .state_dbg(state_dbg)
    );

    // ---------------- DUT with XE_LAT = 3 ----------------
    logic         key_start3, key_ready3, busy3, done3, keys_valid3;
    logic [127:0] xe_temp_key3, xe_m_key3, xe_out_key3, rk_rd_data3;
    logic [31:0]  xe_rcon3;
    logic [3:0]   rk_rd_addr3;
    logic [1:0]   state_dbg3;

    aes_key_sched_ctrl #(.NR(NR), .XE_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .key_in(key_in), .key_start(key_start3),
        .key_ready(key_ready3), .busy(busy3), .done(done3), .keys_valid(keys_valid3),
        .xe_temp_key(xe_temp_key3), .xe_m_key(xe_m_key3), .xe_rcon(xe_rcon3),
        .xe_out_key(xe_out_key3), .rk_rd_addr(rk_rd_addr3), .rk_rd_data(rk_rd_data3),
        .state_dbg(state_dbg3)
    );

    // ---------------- reference AES key expansion ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return v[7] ? ({v[6:0], 1'b0} ^ 8'h1b) : {v[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int x = 1; x < 256; x++) begin
            if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rc_of(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int j = 2; j <= r; j++) v = xtime(v);
        return v;
    endfunction

    function automatic logic [127:0] key_expand_f(input logic [127:0] t, input logic [31:0] rcon);
        logic [31:0] w3, rot, sub, n0, n1, n2, n3;
        w3  = t[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]};
        n0  = t[127:96] ^ sub ^ rcon;
        n1  = t[95:64] ^ n0;
        n2  = t[63:32] ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    initial begin
        for (int a = 0; a < 256; a++) sbox[a] = sbox_calc(8'(a));
    end

    // Delayed datapath models: one register stage and three register stages.
    logic [127:0] pipe3 [3];
    always @(posedge clk) xe_out_key <= key_expand_f(xe_temp_key, xe_rcon);
    always @(posedge clk) begin
        pipe3[0] <= key_expand_f(xe_temp_key3, xe_rcon3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign xe_out_key3 = pipe3[2];

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_keys(input logic [127:0] key);
        logic [127:0] k;
        k = key;
        exp_q.push_back(k);
        for (int r = 1; r <= NR; r++) begin
            k = key_expand_f(k, {rc_of(r), 24'h0});
            exp_q.push_back(k);
        end
    endtask

    task automatic read_and_pop(input string tag);
        logic [127:0] e;
        for (int i = 0; i <= NR; i++) begin
            rk_rd_addr = 4'(i);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            check($sformatf("%s rk[%0d]", tag, i), rk_rd_data, e);
        end
    endtask

    // ---------------- driver ----------------
    // One full expansion on the latency-1 DUT, checked every cycle. Cycle k is
    // the k-th cycle after the accept edge; the done pulse belongs in cycle 21.
    task automatic run_expansion(input string tag, input logic [127:0] key, input bit skip_start,
                                 input bit pulses, input bit chain, input logic [127:0] next_key);
        logic [31:0] exp_rc;
        if (!skip_start) begin
            @(negedge clk);
            key_in = key; key_start = 1'b1;
            push_keys(key);
            @(negedge clk);
            key_start = 1'b0;
        end
        for (int k = 1; k <= 21; k++) begin
            exp_rc = (k <= 20) ? {rc_of((k + 1) / 2), 24'h0} : 32'h0;
            check($sformatf("%s xe_rcon c%0d", tag, k), xe_rcon, exp_rc);
            check($sformatf("%s busy c%0d", tag, k), busy, k <= 20);
            check($sformatf("%s done c%0d", tag, k), done, k == 21);
            check($sformatf("%s key_ready c%0d", tag, k), key_ready, k == 21);
            check($sformatf("%s keys_valid c%0d", tag, k), keys_valid, 1'b0);
            if (k <= 20)
                check($sformatf("%s xe_temp_key c%0d", tag, k), xe_temp_key, exp_q[(k - 1) / 2]);
            if (k == 21) read_and_pop(tag);
            if (k == 21 && chain) begin
                key_in = next_key; key_start = 1'b1;
                push_keys(next_key);
            end else if (pulses && (k == 3 || k == 10)) begin
                key_in = {$urandom, $urandom, $urandom, $urandom};
                key_start = 1'b1;
            end else begin
                key_start = 1'b0;
            end
            @(negedge clk);
        end
        key_start = 1'b0;
        if (!chain) begin
            check({tag, " post done"}, done, 1'b0);
            check({tag, " post busy"}, busy, 1'b0);
            check({tag, " post keys_valid"}, keys_valid, 1'b1);
            check({tag, " post key_ready"}, key_ready, 1'b1);
            check({tag, " post xe_rcon"}, xe_rcon, 32'h0);
            check({tag, " post state"}, state_dbg, 2'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  cyc;
        bit  seen_done;
        rst = 1'b1; key_start = 1'b0; key_start3 = 1'b0; key_in = '0;
        rk_rd_addr = '0; rk_rd_addr3 = '0;
        repeat (3) @(negedge clk);

        check("rst key_ready", key_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst keys_valid", keys_valid, 1'b0);
        check("rst xe_temp_key", xe_temp_key, 128'h0);
        check("rst xe_rcon", xe_rcon, 32'h0);
        check("rst xe_m_key", xe_m_key, 128'h0);
        check("rst state", state_dbg, 2'd0);
        check("rst rk[0]", rk_rd_data, 128'h0);
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);

        // FIPS-197 key: per-cycle rcon/handshake sequence and full key file.
        run_expansion("t1", KEY_FIPS, 1'b0, 1'b0, 1'b0, '0);
        rk_rd_addr = 4'd1;  #1; check("t1 fips rk1", rk_rd_data, FIPS_RK1);
        rk_rd_addr = 4'd10; #1; check("t1 fips rk10", rk_rd_data, FIPS_RK10);
        for (int a = 11; a <= 15; a++) begin
            rk_rd_addr = 4'(a); #1;
            check($sformatf("t1 oob addr %0d", a), rk_rd_data, 128'h0);
        end
        check("t1 xe_m_key", xe_m_key, 128'h0);

        // Starts pulsed mid-expansion with junk keys must change nothing.
        repeat ($urandom_range(1, 3)) @(negedge clk);
        run_expansion("t3", KEY_FIPS, 1'b0, 1'b1, 1'b0, '0);
        rk_rd_addr = 4'd10; #1; check("t3 fips rk10", rk_rd_data, FIPS_RK10);

        // Reset in the middle of an expansion.
        @(negedge clk);
        key_in = KEY_SEQ; key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4 key_ready", key_ready, 1'b1);
        check("t4 busy", busy, 1'b0);
        check("t4 keys_valid", keys_valid, 1'b0);
        check("t4 xe_rcon", xe_rcon, 32'h0);
        check("t4 xe_temp_key", xe_temp_key, 128'h0);
        for (int a = 0; a <= 15; a++) begin
            rk_rd_addr = 4'(a); #1;
            check($sformatf("t4 cleared rk[%0d]", a), rk_rd_data, 128'h0);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("t4 no done after reset", seen_done, 1'b0);

        // Back-to-back: second start accepted in the DONE cycle.
        run_expansion("t5a", KEY_FIPS, 1'b0, 1'b0, 1'b1, KEY_SEQ);
        run_expansion("t5b", KEY_SEQ, 1'b1, 1'b0, 1'b0, '0);
        rk_rd_addr = 4'd10; #1; check("t5 seq rk10", rk_rd_data, SEQ_RK10);

        // Latency-3 datapath build.
        @(negedge clk);
        key_in = KEY_FIPS; key_start3 = 1'b1;
        push_keys(KEY_FIPS);
        @(negedge clk);
        key_start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t6 done latency", 128'(cyc), 128'd41);
        for (int i = 0; i <= NR; i++) begin
            rk_rd_addr3 = 4'(i); #1;
            check($sformatf("t6 rk[%0d]", i), rk_rd_data3,
                  (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
        end
        rk_rd_addr3 = 4'd10; #1; check("t6 fips rk10", rk_rd_data3, FIPS_RK10);
        for (int a = 11; a <= 15; a++) begin
            rk_rd_addr3 = 4'(a); #1;
            check($sformatf("t6 oob addr %0d", a), rk_rd_data3, 128'h0);
        end
        @(negedge clk);
        check("t6 keys_valid", keys_valid3, 1'b1);
        check("t6 queue drained", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
